// File: rtl/eros_obi_to_axil_master.sv
// OBI subordinate to AXI4-Lite manager bridge, one transaction outstanding.
// Optional response timeout with drain of the abandoned AXI transaction: EROS_OBI_AXIL_TIMEOUT_EN.
module eros_obi_to_axil_master #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter logic [2:0]  AXI_PROT       = 3'b000,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    obi_req_i,
    output logic                    obi_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   obi_addr_i,
    input  logic                    obi_we_i,
    input  logic [DATA_WIDTH/8-1:0] obi_be_i,
    input  logic [DATA_WIDTH-1:0]   obi_wdata_i,
    output logic                    obi_rvalid_o,
    output logic [DATA_WIDTH-1:0]   obi_rdata_o,
    output logic                    obi_err_o,
    output logic [ADDR_WIDTH-1:0]   m_awaddr_o,
    output logic [2:0]              m_awprot_o,
    output logic                    m_awvalid_o,
    input  logic                    m_awready_i,
    output logic [DATA_WIDTH-1:0]   m_wdata_o,
    output logic [DATA_WIDTH/8-1:0] m_wstrb_o,
    output logic                    m_wvalid_o,
    input  logic                    m_wready_i,
    input  logic [1:0]              m_bresp_i,
    input  logic                    m_bvalid_i,
    output logic                    m_bready_o,
    output logic [ADDR_WIDTH-1:0]   m_araddr_o,
    output logic [2:0]              m_arprot_o,
    output logic                    m_arvalid_o,
    input  logic                    m_arready_i,
    input  logic [DATA_WIDTH-1:0]   m_rdata_i,
    input  logic [1:0]              m_rresp_i,
    input  logic                    m_rvalid_i,
    output logic                    m_rready_o,
    output logic                    timeout_o
);

`ifdef EROS_OBI_AXIL_TIMEOUT_EN
    typedef enum logic [2:0] {IDLE, WRITE, WAIT_B, READ, WAIT_R, RESP, DRAIN} state_t;
`else
    typedef enum logic [2:0] {IDLE, WRITE, WAIT_B, READ, WAIT_R, RESP} state_t;
`endif

    state_t                    state_q, state_d;
    logic [ADDR_WIDTH-1:0]     addr_q;
    logic                      we_q;
    logic [DATA_WIDTH/8-1:0]   be_q;
    logic [DATA_WIDTH-1:0]     wdata_q, rdata_q;
    logic                      err_q, aw_done_q, w_done_q, ar_done_q;
    logic                      gnt, aw_hs, w_hs, ar_hs, b_hs, r_hs, pending;
    logic                      unused_ok;
`ifdef EROS_OBI_AXIL_TIMEOUT_EN
    logic [31:0]               cnt_q;
    logic                      to_q, to_fire, rsp_done_q, busy;
`endif

    assign unused_ok = ^{m_bresp_i[0], m_rresp_i[0], TIMEOUT_CYCLES[0]};

    // After a timeout the abandoned AXI transaction is still driven until it completes.
`ifdef EROS_OBI_AXIL_TIMEOUT_EN
    assign pending = to_q && (state_q == RESP || state_q == DRAIN) && !rsp_done_q;
    assign busy    = state_q inside {WRITE, WAIT_B, READ, WAIT_R};
`else
    assign pending = 1'b0;
`endif

    assign m_awvalid_o  = we_q && !aw_done_q && (state_q == WRITE || pending);
    assign m_wvalid_o   = we_q && !w_done_q && (state_q == WRITE || pending);
    assign m_arvalid_o  = !we_q && !ar_done_q && (state_q == READ || pending);
    assign m_bready_o   = (state_q == WAIT_B) || (pending && we_q);
    assign m_rready_o   = (state_q == WAIT_R) || (pending && !we_q);
    assign m_awaddr_o   = addr_q;
    assign m_araddr_o   = addr_q;
    assign m_awprot_o   = AXI_PROT;
    assign m_arprot_o   = AXI_PROT;
    assign m_wdata_o    = wdata_q;
    assign m_wstrb_o    = be_q;

    assign aw_hs = m_awvalid_o && m_awready_i;
    assign w_hs  = m_wvalid_o && m_wready_i;
    assign ar_hs = m_arvalid_o && m_arready_i;
    assign b_hs  = m_bready_o && m_bvalid_i;
    assign r_hs  = m_rready_o && m_rvalid_i;

    assign obi_gnt_o    = gnt;
    assign obi_rvalid_o = (state_q == RESP);
    assign obi_rdata_o  = rdata_q;
    assign obi_err_o    = (state_q == RESP) && err_q;
`ifdef EROS_OBI_AXIL_TIMEOUT_EN
    assign timeout_o    = (state_q == RESP) && to_q;
`else
    assign timeout_o    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        gnt     = 1'b0;
`ifdef EROS_OBI_AXIL_TIMEOUT_EN
        to_fire = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                gnt = obi_req_i;
                if (obi_req_i) state_d = obi_we_i ? WRITE : READ;
            end
            WRITE:  if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = WAIT_B;
            WAIT_B: if (b_hs) state_d = RESP;
            READ:   if (ar_hs) state_d = WAIT_R;
            WAIT_R: if (r_hs) state_d = RESP;
`ifdef EROS_OBI_AXIL_TIMEOUT_EN
            RESP:   state_d = to_q ? DRAIN : IDLE;
            DRAIN:  if (rsp_done_q || b_hs || r_hs) state_d = IDLE;
`else
            RESP:   state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
`ifdef EROS_OBI_AXIL_TIMEOUT_EN
        // A response arriving in the final allowed cycle still wins over the timeout.
        if (busy && cnt_q == 32'(TIMEOUT_CYCLES - 1) && state_d != RESP) begin
            to_fire = 1'b1;
            state_d = RESP;
        end
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            we_q      <= 1'b0;
            be_q      <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            ar_done_q <= 1'b0;
`ifdef EROS_OBI_AXIL_TIMEOUT_EN
            cnt_q      <= '0;
            to_q       <= 1'b0;
            rsp_done_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (gnt) begin
                addr_q    <= obi_addr_i;
                we_q      <= obi_we_i;
                be_q      <= obi_be_i;
                wdata_q   <= obi_wdata_i;
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
                ar_done_q <= 1'b0;
            end else begin
                if (aw_hs) aw_done_q <= 1'b1;
                if (w_hs)  w_done_q  <= 1'b1;
                if (ar_hs) ar_done_q <= 1'b1;
            end
            if (state_q == WAIT_B && b_hs) begin
                rdata_q <= '0;
                err_q   <= m_bresp_i[1];
            end
            if (state_q == WAIT_R && r_hs) begin
                rdata_q <= m_rdata_i;
                err_q   <= m_rresp_i[1];
            end
`ifdef EROS_OBI_AXIL_TIMEOUT_EN
            if (gnt) begin
                cnt_q      <= '0;
                to_q       <= 1'b0;
                rsp_done_q <= 1'b0;
            end else if (busy) begin
                cnt_q <= cnt_q + 32'd1;
            end
            if (to_fire) begin
                rdata_q <= DATA_WIDTH'(32'hDEAD_BEEF);
                err_q   <= 1'b1;
                to_q    <= 1'b1;
            end
            if (pending && (b_hs || r_hs)) rsp_done_q <= 1'b1;
`endif
        end
    end

endmodule
